// File: rtl/alu_pkg.sv
// alu_pkg: MIPS opcode/func codes and shared enums for alu_md
package alu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_JR = 6'h08, F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {MULT, MULTU, DIV, DIVU} md_op_t;
endpackage

// File: rtl/alu_md_iter.sv
// alu_md_iter: iterative shift-add multiply / restoring divide on magnitudes, WIDTH steps after start
//   clk, rst_n      clock, synchronous active-low reset (aborts a running op)
//   start, op       load operands and begin mult/multu/div/divu
//   a, b            operands sampled on start
//   done            high during the final step; hi_out/lo_out are valid then
//   hi_out, lo_out  sign-corrected HI/LO of the finishing operation
module alu_md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, nxt, prod;
  logic [WIDTH-1:0] m, ao, ma, mb, rem_n, rem, q;
  logic [WIDTH:0] sh, s;
  logic sgn, dv, is_div, na, nb, bz, ge;
  assign sgn = op == MULT || op == DIV;
  assign dv = op == DIV || op == DIVU;
  assign ma = sgn && a[WIDTH-1] ? -a : a;
  assign mb = sgn && b[WIDTH-1] ? -b : b;
  // acc holds the partial product for multiply, {remainder, quotient} for divide
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      m <= '0;
      ao <= '0;
      {is_div, na, nb, bz} <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      acc <= {{WIDTH{1'b0}}, dv ? ma : mb};
      m <= dv ? mb : ma;
      ao <= a;
      is_div <= dv;
      na <= sgn && a[WIDTH-1];
      nb <= sgn && b[WIDTH-1];
      bz <= b == '0;
    end else if (cnt != '0) begin
      acc <= nxt;
      cnt <= cnt - CW'(1);
    end
  assign s = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
  assign sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge = sh >= {1'b0, m};
  // a successful trial subtract is below the divisor, so WIDTH bits suffice
  assign rem_n = ge ? sh[WIDTH-1:0] - m : sh[WIDTH-1:0];
  assign nxt = is_div ? {rem_n, acc[WIDTH-2:0], ge} : {s, acc[WIDTH-1:1]};
  assign prod = na ^ nb ? -nxt : nxt;
  assign q = na ^ nb ? -nxt[WIDTH-1:0] : nxt[WIDTH-1:0];
  assign rem = na ? -nxt[2*WIDTH-1:WIDTH] : nxt[2*WIDTH-1:WIDTH];
  assign lo_out = is_div ? (bz ? '1 : q) : prod[WIDTH-1:0];
  assign hi_out = is_div ? (bz ? ao : rem) : prod[2*WIDTH-1:WIDTH];
  assign done = cnt == CW'(1);
endmodule

// File: rtl/alu_md.sv
// alu_md: registered MIPS execute ALU with handshake, zero/ovf flags and optional mult/div (ALU_MD_EN)
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  operation handshake; in_ready low while mult/div runs
//   opcode, func, sa    MIPS opcode, func and shift amount
//   a, b                rs operand; rt operand or sign-extended immediate
//   out_valid           one-cycle pulse with result, zero, ovf, illegal
//   hi, lo              HI/LO registers (tied to 0 unless ALU_MD_EN is defined)
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SA_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic [SA_W-1:0]  sa,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int IW = WIDTH < 16 ? WIDTH : 16;
  logic [WIDTH-1:0] sum, dif, imm, res, md_lo;
  logic aov, sov, ov, ill, md, accept, done;
  assign sum = a + b;
  assign dif = a - b;
  assign aov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sov = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
  assign accept = in_valid && in_ready;
  always_comb begin
    imm = '0;
    imm[IW-1:0] = b[IW-1:0];
  end
  always_comb begin
    res = '0;
    ov = 1'b0;
    ill = 1'b0;
    md = 1'b0;
    if (opcode == OP_RTYPE)
      case (func)
        F_SLL:   res = b << sa;
        F_SRL:   res = b >> sa;
        F_SRA:   res = $signed(b) >>> sa;
        F_SLLV:  res = b << a[SA_W-1:0];
        F_SRLV:  res = b >> a[SA_W-1:0];
        F_SRAV:  res = $signed(b) >>> a[SA_W-1:0];
        F_JR:    res = '0;
        F_ADD:   begin res = sum; ov = aov; end
        F_ADDU:  res = sum;
        F_SUB:   begin res = dif; ov = sov; end
        F_SUBU:  res = dif;
        F_AND:   res = a & b;
        F_OR:    res = a | b;
        F_XOR:   res = a ^ b;
        F_NOR:   res = ~(a | b);
        F_SLT:   res = WIDTH'($signed(a) < $signed(b));
        F_SLTU:  res = WIDTH'(a < b);
`ifdef ALU_MD_EN
        F_MFHI:  res = hi;
        F_MFLO:  res = lo;
        F_MULT, F_MULTU, F_DIV, F_DIVU: md = 1'b1;
`endif
        default: ill = 1'b1;
      endcase
    else
      case (opcode)
        OP_J, OP_JAL:   res = '0;
        OP_BEQ, OP_BNE: res = dif;
        OP_ADDI:        begin res = sum; ov = aov; end
        OP_ADDIU:       res = sum;
        OP_ANDI:        res = a & imm;
        OP_ORI:         res = a | imm;
        OP_XORI:        res = a ^ imm;
        OP_LW, OP_SW:   res = sum;
        default:        ill = 1'b1;
      endcase
  end
`ifdef ALU_MD_EN
  state_t state, state_n;
  logic [WIDTH-1:0] md_hi;
  alu_md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept && md),
    .op(md_op_t'(func[1:0])),
    .a(a),
    .b(b),
    .done(done),
    .hi_out(md_hi),
    .lo_out(md_lo)
  );
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
  always_comb state_n = state == IDLE ? (accept && md ? RUN : IDLE) : (done ? IDLE : RUN);
  assign in_ready = state == IDLE;
  always_ff @(posedge clk)
    if (!rst_n) {hi, lo} <= '0;
    else if (done) {hi, lo} <= {md_hi, md_lo};
`else
  assign done = 1'b0;
  assign md_lo = '0;
  assign in_ready = 1'b1;
  assign hi = '0;
  assign lo = '0;
`endif
  // a finishing mult/div and a new accept never coincide: in_ready is low during RUN
  always_ff @(posedge clk)
    if (!rst_n) begin
      result <= '0;
      zero <= 1'b1;
      ovf <= 1'b0;
      illegal <= 1'b0;
      out_valid <= 1'b0;
    end else if (done) begin
      result <= md_lo;
      zero <= md_lo == '0;
      ovf <= 1'b0;
      illegal <= 1'b0;
      out_valid <= 1'b1;
    end else if (accept && !md) begin
      result <= res;
      zero <= res == '0;
      ovf <= ov;
      illegal <= ill;
      out_valid <= 1'b1;
    end else out_valid <= 1'b0;
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: scoreboard bench for alu_md; mult/div behaviour checked when ALU_MD_EN is defined
module tb_alu_md;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic in_ready, out_valid, zero, ovf, illegal;
  logic [5:0] opcode = '0, func = '0;
  logic [4:0] sa = '0;
  logic [W-1:0] a = '0, b = '0, result, hi, lo;
  typedef struct {
    logic [W-1:0] res, hi, lo;
    logic z, v, il, hl;
    int cyc, id;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int checks = 0, errors = 0, cyc = 0, nid = 0;

  alu_md #(.WIDTH(W), .SA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func(func), .sa(sa), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .zero(zero), .ovf(ovf),
    .illegal(illegal), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // called on a falling edge; returns on the falling edge after the accepting edge
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                       input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] r,
                       input logic v, input logic il, input logic md, input logic [W-1:0] eh,
                       input bit push, output int stall);
    exp_t e;
    stall = 0;
    opcode = op; func = fn; sa = s; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && stall < 200) begin
      @(negedge clk);
      stall++;
    end
    check("accept_ready", in_ready, 1);
    e.res = r; e.z = r == '0; e.v = v; e.il = il; e.hl = md; e.hi = eh; e.lo = r;
    e.cyc = cyc + 1 + (md ? W : 0);
    e.id = nid++;
    if (push) q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic alu(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                     input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] r,
                     input logic v, input logic il);
    int st;
    drive(op, fn, s, x, y, r, v, il, 1'b0, '0, 1'b1, st);
  endtask

  task automatic mdop(input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] eh, input logic [W-1:0] el);
    int st;
`ifdef ALU_MD_EN
    drive(6'h00, fn, 5'd0, x, y, el, 1'b0, 1'b0, 1'b1, eh, 1'b1, st);
`else
    drive(6'h00, fn, 5'd0, x, y, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1, st);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
  endtask

  always @(negedge clk)
    if (out_valid) begin
      if (q.size() == 0) check("spurious_out_valid", out_valid, 0);
      else begin
        m = q.pop_front();
        check($sformatf("op%0d_result", m.id), result, m.res);
        check($sformatf("op%0d_zero", m.id), zero, m.z);
        check($sformatf("op%0d_ovf", m.id), ovf, m.v);
        check($sformatf("op%0d_illegal", m.id), illegal, m.il);
        check($sformatf("op%0d_latency", m.id), cyc, m.cyc);
        if (m.hl) begin
          check($sformatf("op%0d_hi", m.id), hi, m.hi);
          check($sformatf("op%0d_lo", m.id), lo, m.lo);
        end
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int st;
    repeat (3) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_illegal", illegal, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst_n = 1'b1;
    @(negedge clk);
    alu(6'h00, 6'h20, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0);
    alu(6'h00, 6'h21, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0);
    alu(6'h00, 6'h22, 0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0);
    alu(6'h00, 6'h23, 0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 0);
    alu(6'h00, 6'h2A, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0);
    alu(6'h00, 6'h2B, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0);
    alu(6'h00, 6'h03, 4, 32'h00000000, 32'h80000000, 32'hF8000000, 0, 0);
    alu(6'h00, 6'h00, 31, 32'h00000000, 32'h00000001, 32'h80000000, 0, 0);
    alu(6'h00, 6'h02, 31, 32'h00000000, 32'h80000000, 32'h00000001, 0, 0);
    alu(6'h00, 6'h04, 0, 32'h00000004, 32'h00000003, 32'h00000030, 0, 0);
    alu(6'h00, 6'h06, 0, 32'h00000001, 32'hF0000000, 32'h78000000, 0, 0);
    alu(6'h00, 6'h07, 0, 32'h00000024, 32'hF0000000, 32'hFF000000, 0, 0);
    alu(6'h00, 6'h24, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0);
    alu(6'h00, 6'h25, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0);
    alu(6'h00, 6'h26, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0);
    alu(6'h00, 6'h27, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0);
    alu(6'h08, 6'h00, 0, 32'h00000005, 32'hFFFFFFFF, 32'h00000004, 0, 0);
    alu(6'h08, 6'h00, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1, 0);
    alu(6'h09, 6'h00, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 0, 0);
    alu(6'h0C, 6'h00, 0, 32'hFFFFFFFF, 32'hFFFF1234, 32'h00001234, 0, 0);
    alu(6'h0D, 6'h00, 0, 32'h00000000, 32'hFFFF8000, 32'h00008000, 0, 0);
    alu(6'h0E, 6'h00, 0, 32'h0000FFFF, 32'hFFFF00FF, 32'h0000FF00, 0, 0);
    alu(6'h23, 6'h00, 0, 32'h00001000, 32'hFFFFFFFC, 32'h00000FFC, 0, 0);
    alu(6'h2B, 6'h00, 0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0);
    alu(6'h02, 6'h00, 0, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, 0);
    alu(6'h00, 6'h08, 0, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, 0);
    alu(6'h04, 6'h00, 0, 32'h00000005, 32'h00000005, 32'h00000000, 0, 0);
    alu(6'h05, 6'h00, 0, 32'h00000005, 32'h00000006, 32'hFFFFFFFF, 0, 0);
    alu(6'h0F, 6'h00, 0, 32'h00000001, 32'h00000001, 32'h00000000, 0, 1);
    alu(6'h00, 6'h01, 0, 32'h00000001, 32'h00000001, 32'h00000000, 0, 1);
`ifdef ALU_MD_EN
    mdop(6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    drive(6'h00, 6'h10, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, '0, 1, st);
    check("mult_stall_cycles", st, W);
`else
    mdop(6'h18, 32'hFFFFFFFD, 32'h00000005, 0, 0);
    alu(6'h00, 6'h10, 0, 0, 0, 32'h00000000, 0, 1);
    alu(6'h00, 6'h12, 0, 0, 0, 32'h00000000, 0, 1);
`endif
    mdop(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    mdop(6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    mdop(6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    mdop(6'h1B, 32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF);
    mdop(6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    mdop(6'h1B, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
`ifdef ALU_MD_EN
    alu(6'h00, 6'h12, 0, 0, 0, 32'h0FFFFFFF, 0, 0);
`endif
    alu(6'h00, 6'h21, 0, 32'h00000001, 32'h00000001, 32'h00000002, 0, 0);
    drain();
`ifdef ALU_MD_EN
    drive(6'h00, 6'h18, 0, 32'h00000003, 32'h00000004, '0, 0, 0, 1, '0, 0, st);
    repeat (9) @(negedge clk);
    check("run_in_ready_low", in_ready, 0);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 1);
    rst_n = 1'b1;
    repeat (W + 8) @(negedge clk);
`ifdef ALU_MD_EN
    alu(6'h00, 6'h10, 0, 0, 0, 32'h00000000, 0, 0);
    alu(6'h00, 6'h12, 0, 0, 0, 32'h00000000, 0, 0);
`endif
    alu(6'h00, 6'h22, 0, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
